// File: rtl/btb_update_scheduler.sv
// rtl/btb_update_scheduler.sv - serialises BTB/BHT updates onto one write port; init sweep after reset.
// Optional statistics counters are enabled by defining BTB_SCHED_STATS_EN.
module btb_update_scheduler #(
    parameter int WORD_SIZE  = 16,
    parameter int IDX_SIZE   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          br_valid,
    input  logic [WORD_SIZE-1:0]          br_pc,
    input  logic                          br_taken,
    input  logic [WORD_SIZE-1:0]          br_target,
    input  logic                          br_mispredict,
    input  logic                          jmp_valid,
    input  logic [WORD_SIZE-1:0]          jmp_pc,
    input  logic [WORD_SIZE-1:0]          jmp_target,
    output logic                          upd_valid,
    output logic [IDX_SIZE-1:0]           upd_idx,
    output logic [WORD_SIZE-IDX_SIZE-1:0] upd_tag,
    output logic [WORD_SIZE-1:0]          upd_target,
    output logic [1:0]                    upd_op,
    output logic                          init_busy,
    output logic                          stall_req,
    output logic                          overflow
`ifdef BTB_SCHED_STATS_EN
    ,
    output logic [15:0]                   stat_issued,
    output logic [15:0]                   stat_squash,
    output logic [15:0]                   stat_drop
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FW    = CNT_W + 1;
    localparam int TAG_W = WORD_SIZE - IDX_SIZE;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] target;
        logic [1:0]           op;
    } entry_t;

    state_t               state_q, state_d;
    logic [IDX_SIZE-1:0]  sweep_q, sweep_d;
    logic                 init_busy_q, init_busy_d;
    logic                 overflow_q, overflow_d;
    logic                 upd_valid_q, upd_valid_d;
    logic [IDX_SIZE-1:0]  upd_idx_q, upd_idx_d;
    logic [TAG_W-1:0]     upd_tag_q, upd_tag_d;
    logic [WORD_SIZE-1:0] upd_target_q, upd_target_d;
    logic [1:0]           upd_op_q, upd_op_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    entry_t               mem_q [FIFO_DEPTH];
    entry_t               mem_d [FIFO_DEPTH];

    logic                 do_pop;
    logic                 squash;
    logic [1:0]           pushes;
    logic [1:0]           drops;
    logic [PTR_W-1:0]     wp;
    logic [FW-1:0]        free;
    entry_t               ent;

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        init_busy_d  = (state_q == ST_INIT);
        overflow_d   = overflow_q;
        upd_valid_d  = 1'b0;
        upd_idx_d    = upd_idx_q;
        upd_tag_d    = upd_tag_q;
        upd_target_d = upd_target_q;
        upd_op_d     = upd_op_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        do_pop       = 1'b0;
        squash       = 1'b0;
        pushes       = 2'd0;
        drops        = 2'd0;
        wp           = wr_ptr_q;
        free         = '0;
        ent          = mem_q[rd_ptr_q];

        if (state_q == ST_INIT) begin
            upd_valid_d  = 1'b1;
            upd_op_d     = OP_CLEAR;
            upd_idx_d    = sweep_q;
            upd_tag_d    = '1;
            upd_target_d = '0;
            sweep_d      = sweep_q + 1'b1;
            if (sweep_q == '1) begin
                state_d = ST_RUN;
            end
        end else begin
            do_pop = (count_q != '0);
            if (do_pop) begin
                upd_valid_d  = 1'b1;
                upd_idx_d    = ent.pc[IDX_SIZE-1:0];
                upd_tag_d    = ent.pc[WORD_SIZE-1:IDX_SIZE];
                upd_target_d = ent.target;
                upd_op_d     = ent.op;
                rd_ptr_d     = rd_ptr_q + 1'b1;
            end

            // Slots freed by this cycle's pop are reusable by this cycle's pushes.
            free   = FW'(FIFO_DEPTH) - FW'(count_q) + FW'(do_pop);
            squash = jmp_valid && br_valid && br_mispredict;

            if (br_valid) begin
                if (free != '0) begin
                    mem_d[wp].pc     = br_pc;
                    mem_d[wp].target = br_target;
                    mem_d[wp].op     = br_taken ? OP_INC : OP_DEC;
                    wp     = wp + 1'b1;
                    free   = free - 1'b1;
                    pushes = pushes + 1'b1;
                end else begin
                    drops = drops + 1'b1;
                end
            end

            if (jmp_valid && !squash) begin
                if (free != '0) begin
                    mem_d[wp].pc     = jmp_pc;
                    mem_d[wp].target = jmp_target;
                    mem_d[wp].op     = OP_INC;
                    wp     = wp + 1'b1;
                    pushes = pushes + 1'b1;
                end else begin
                    drops = drops + 1'b1;
                end
            end

            wr_ptr_d = wp;
            count_d  = count_q + CNT_W'(pushes) - CNT_W'(do_pop);
            if (drops != 2'd0) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            init_busy_q  <= 1'b1;
            overflow_q   <= 1'b0;
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= '0;
            upd_tag_q    <= '0;
            upd_target_q <= '0;
            upd_op_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            init_busy_q  <= init_busy_d;
            overflow_q   <= overflow_d;
            upd_valid_q  <= upd_valid_d;
            upd_idx_q    <= upd_idx_d;
            upd_tag_q    <= upd_tag_d;
            upd_target_q <= upd_target_d;
            upd_op_q     <= upd_op_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign upd_valid  = upd_valid_q;
    assign upd_idx    = upd_idx_q;
    assign upd_tag    = upd_tag_q;
    assign upd_target = upd_target_q;
    assign upd_op     = upd_op_q;
    assign init_busy  = init_busy_q;
    assign overflow   = overflow_q;
    assign stall_req  = init_busy_q || (count_q >= CNT_W'(FIFO_DEPTH - 1));

`ifdef BTB_SCHED_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d;
    logic [15:0] stat_squash_q, stat_squash_d;
    logic [15:0] stat_drop_q, stat_drop_d;

    always_comb begin
        stat_issued_d = stat_issued_q + 16'(do_pop);
        stat_squash_d = stat_squash_q + 16'(squash && (state_q == ST_RUN));
        stat_drop_d   = stat_drop_q + 16'(drops);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued_q <= '0;
            stat_squash_q <= '0;
            stat_drop_q   <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_squash_q <= stat_squash_d;
            stat_drop_q   <= stat_drop_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_squash = stat_squash_q;
    assign stat_drop   = stat_drop_q;
`endif

endmodule
